sdrc_xfr_engine: RTL
====================

Name: sdrc_xfr_engine

Overview:
Controller-side responder for the sdr_req command/data interface driven by the Wishbone bridge's command, write-data and read-data FIFOs. It runs in the SDRAM clock domain and does the following:
- accepts one request at a time and acknowledges it;
- sequences write beats with sdr_wr_next, or returns read beats with sdr_rd_valid/sdr_last_rd;
- executes each beat on a simple synchronous memory port;
- inserts periodic refresh windows, during which new requests are blocked.

Parameters:
REF_PERIOD, 780, cycles between refresh requests (counter reload value).
REF_CYCLES, 8, cycles the engine stays in REFRESH.
MEM_AW, 26, width of mem_addr; the running word address wraps modulo 2^MEM_AW.

Ports:
sdram_clk  in  1  single clock; all logic on rising edge
sdram_resetn  in  1  asynchronous active-low reset
sdr_req  in  1  request pending (command FIFO not empty)
sdr_req_addr  in  26  start word address
sdr_req_len  in  9  beat count; 0 is treated as 1
sdr_req_wr_n  in  1  0 = write, 1 = read
sdr_req_ack  out  1  one-cycle pulse; pops the command FIFO
sdr_busy_n  out  1  1 only when IDLE with no refresh pending
sdr_wr_next  out  1  pops one write beat; data is sampled in the same cycle
sdr_wr_en_n  in  4  active-low byte enables of the current write beat
sdr_wr_data  in  32  current write beat (FIFO head, valid combinationally)
sdr_rd_valid  out  1  read beat valid
sdr_last_rd  out  1  qualifies the final read beat of a request
sdr_rd_data  out  32  read beat data
mem_addr  out  MEM_AW  memory word address
mem_wr  out  1  memory write strobe
mem_rd  out  1  memory read strobe; mem_rdata is valid the next cycle
mem_be  out  4  active-high byte enables (~sdr_wr_en_n)
mem_wdata  out  32  memory write data
mem_rdata  in  32  memory read data, 1-cycle latency

Behaviour:
- Reset (asynchronous, sdram_resetn=0):
  - state=IDLE;
  - all outputs 0, except sdr_busy_n=1;
  - refresh counter loaded to REF_PERIOD; refresh pending cleared.
  - Reset mid-burst abandons the burst immediately; the FIFOs are reset by the same domain reset.
- Refresh counter: decrements every cycle in every state. At 0 it sets ref_pend and reloads REF_PERIOD. ref_pend clears on entry to REFRESH.
- States: IDLE, REFRESH, WRITE, READ, RD_FLUSH.
- IDLE, priority ref_pend > sdr_req:
  - ref_pend=1 -> REFRESH, and sdr_busy_n=0 from the next cycle.
  - sdr_req=1 (no ref_pend):
    - sdr_req_ack=1 for exactly this cycle;
    - latch addr, beat count (len==0 ? 1 : len) and direction;
    - go to WRITE if wr_n=0, else READ.
  - An ack is never issued in the cycle immediately after leaving a burst or REFRESH, because sdr_req may lag the FIFO pop by one cycle. IDLE ignores sdr_req for its first cycle.
- REFRESH:
  - stays exactly REF_CYCLES cycles, then IDLE;
  - no mem_rd/mem_wr;
  - sdr_busy_n=0.
- WRITE, one beat per cycle:
  - sdr_wr_next=1 and mem_wr=1 combinationally;
  - mem_addr = running address; mem_wdata = sdr_wr_data; mem_be = ~sdr_wr_en_n;
  - address increments, remaining count decrements;
  - after the last beat, go to IDLE;
  - exactly len sdr_wr_next pulses per request, back to back.
- READ:
  - mem_rd=1 with the running address each cycle for len cycles, then RD_FLUSH.
  - Return path is registered:
    - sdr_rd_valid = mem_rd delayed by 1;
    - sdr_rd_data = mem_rdata;
    - sdr_last_rd = 1 on the beat whose mem_rd was the final one.
  - First sdr_rd_valid comes 1 cycle after the first mem_rd; beats are back to back.
- RD_FLUSH: one cycle while the last beat is returned, then IDLE.
- No backpressure on read return: the read-data FIFO must be sized for 512 beats; overflow is the system's responsibility.
- mem_be = 4'b0000 whenever mem_wr=0.
- Address wrap: 2^MEM_AW-1 + 1 -> 0; no error is flagged.
- sdr_busy_n = (state==IDLE) & ~ref_pend.
- A refresh request arriving mid-burst is deferred until the burst finishes; bursts are never split.

Decomposition:
- Package sdrc_xfr_pkg:
  - state enum;
  - constants DW=32, BEW=4, AW=26, LW=9.
- One sub-module, sdrc_ref_timer: refresh counter plus ref_pend flag, with inputs ref_taken and outputs ref_pend.

Test Plan:
- Write, len=1, addr 0x0000010, data 0xDEADBEEF, sdr_wr_en_n=4'b0000 -> one ack; one sdr_wr_next; mem_wr at addr 0x10 with be 4'hF.
- Read, len=4, addr 0x100, memory preloaded with 0x100..0x103 -> 4 consecutive sdr_rd_valid beats with data 0x100..0x103; sdr_last_rd only on the 4th beat; first valid 2 cycles after ack.
- Write, len=0, sdr_wr_en_n=4'b1010 -> treated as 1 beat; mem_be=4'b0101.
- REF_PERIOD=20, REF_CYCLES=8, sdr_req held high continuously:
  - refresh wins over a pending request in IDLE;
  - sdr_busy_n low for 8 cycles with no mem strobes;
  - a 16-beat burst straddling counter expiry is not interrupted and is followed by REFRESH.
- Read, len=3, at addr 2^26-2 -> mem_addr sequence 0x3FFFFFE, 0x3FFFFFF, 0x0000000.
- sdram_resetn asserted during beat 3 of an 8-beat write -> all outputs 0 immediately (sdr_busy_n=1); after release, the next request is accepted normally.

Source files
------------

// File: rtl/sdrc_xfr_pkg.sv
// Shared types and widths for the SDRAM-side transfer engine.
// Both the request port and the memory port use these widths.
package sdrc_xfr_pkg;

    localparam int DW  = 32;
    localparam int BEW = 4;
    localparam int AW  = 26;
    localparam int LW  = 9;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_REFRESH  = 3'd1,
        ST_WRITE    = 3'd2,
        ST_READ     = 3'd3,
        ST_RD_FLUSH = 3'd4
    } state_t;

    // A zero-length request still moves one beat.
    function automatic logic [LW-1:0] eff_len(input logic [LW-1:0] len);
        return (len == '0) ? LW'(1) : len;
    endfunction

endpackage

// File: rtl/sdrc_xfr_engine_if.sv
// Request/data/memory bundle between the bridge FIFOs, the transfer engine and the memory port.
// Handshake: sdr_req_ack pops one command; sdr_wr_next pops one write beat (data sampled that cycle); sdr_rd_valid has no ready.
interface sdrc_xfr_engine_if #(
    parameter int MEM_AW = sdrc_xfr_pkg::AW
);
    import sdrc_xfr_pkg::*;

    logic              sdr_req;
    logic [AW-1:0]     sdr_req_addr;
    logic [LW-1:0]     sdr_req_len;
    logic              sdr_req_wr_n;
    logic              sdr_req_ack;
    logic              sdr_busy_n;
    logic              sdr_wr_next;
    logic [BEW-1:0]    sdr_wr_en_n;
    logic [DW-1:0]     sdr_wr_data;
    logic              sdr_rd_valid;
    logic              sdr_last_rd;
    logic [DW-1:0]     sdr_rd_data;
    logic [MEM_AW-1:0] mem_addr;
    logic              mem_wr;
    logic              mem_rd;
    logic [BEW-1:0]    mem_be;
    logic [DW-1:0]     mem_wdata;
    logic [DW-1:0]     mem_rdata;

    modport slave (
        input  sdr_req, sdr_req_addr, sdr_req_len, sdr_req_wr_n,
        input  sdr_wr_en_n, sdr_wr_data, mem_rdata,
        output sdr_req_ack, sdr_busy_n, sdr_wr_next,
        output sdr_rd_valid, sdr_last_rd, sdr_rd_data,
        output mem_addr, mem_wr, mem_rd, mem_be, mem_wdata
    );

    modport master (
        output sdr_req, sdr_req_addr, sdr_req_len, sdr_req_wr_n,
        output sdr_wr_en_n, sdr_wr_data, mem_rdata,
        input  sdr_req_ack, sdr_busy_n, sdr_wr_next,
        input  sdr_rd_valid, sdr_last_rd, sdr_rd_data,
        input  mem_addr, mem_wr, mem_rd, mem_be, mem_wdata
    );

endinterface

// File: rtl/sdrc_ref_timer.sv
// Free-running refresh interval counter; raises ref_pend each time it expires.
// ref_pend holds until the engine takes the refresh.
module sdrc_ref_timer #(
    parameter int REF_PERIOD = 780
) (
    input  logic sdram_clk,
    input  logic sdram_resetn,
    input  logic ref_taken,
    output logic ref_pend
);

    localparam int CW = $clog2(REF_PERIOD + 1);

    logic [CW-1:0] r_cnt;
    logic          r_pend;

    // Expiry wins over a same-cycle take so a refresh is never lost.
    always_ff @(posedge sdram_clk or negedge sdram_resetn) begin
        if (!sdram_resetn) begin
            r_cnt  <= CW'(REF_PERIOD);
            r_pend <= 1'b0;
        end else if (r_cnt == '0) begin
            r_cnt  <= CW'(REF_PERIOD);
            r_pend <= 1'b1;
        end else begin
            r_cnt <= r_cnt - 1'b1;
            if (ref_taken) begin
                r_pend <= 1'b0;
            end
        end
    end

    assign ref_pend = r_pend;

endmodule

// File: rtl/sdrc_xfr_engine.sv
// Serves one bridge request at a time as a write or read burst on a simple synchronous
// memory port, and slots refresh windows in between bursts.
module sdrc_xfr_engine
    import sdrc_xfr_pkg::*;
#(
    parameter int REF_PERIOD = 780,
    parameter int REF_CYCLES = 8,
    parameter int MEM_AW     = AW
) (
    input  logic             sdram_clk,
    input  logic             sdram_resetn,
    sdrc_xfr_engine_if.slave bus,
    output state_t           o_dbg_state
);

    localparam int RCW = (REF_CYCLES > 1) ? $clog2(REF_CYCLES) : 1;

    state_t            r_state, w_state_nxt;
    logic [MEM_AW-1:0] r_addr, w_addr_nxt;
    logic [LW-1:0]     r_rem, w_rem_nxt;
    logic [RCW-1:0]    r_ref_cnt, w_ref_cnt_nxt;
    logic              r_hold, w_hold_nxt;
    logic              r_rd_valid;
    logic              r_rd_last;

    logic              w_ref_pend;
    logic              w_ref_taken;
    logic              w_ack;
    logic              w_wr_next;
    logic              w_mem_wr;
    logic              w_mem_rd;
    logic [BEW-1:0]    w_be;
    logic              w_last_beat;

    sdrc_ref_timer #(
        .REF_PERIOD (REF_PERIOD)
    ) u_ref_timer (
        .sdram_clk    (sdram_clk),
        .sdram_resetn (sdram_resetn),
        .ref_taken    (w_ref_taken),
        .ref_pend     (w_ref_pend)
    );

    // r_hold masks sdr_req for the first IDLE cycle: the request line may lag the FIFO pop.
    always_ff @(posedge sdram_clk or negedge sdram_resetn) begin
        if (!sdram_resetn) begin
            r_state   <= ST_IDLE;
            r_addr    <= '0;
            r_rem     <= '0;
            r_ref_cnt <= '0;
            r_hold    <= 1'b1;
        end else begin
            r_state   <= w_state_nxt;
            r_addr    <= w_addr_nxt;
            r_rem     <= w_rem_nxt;
            r_ref_cnt <= w_ref_cnt_nxt;
            r_hold    <= w_hold_nxt;
        end
    end

    assign w_last_beat = (r_rem == LW'(1));

    always_comb begin
        w_state_nxt   = r_state;
        w_addr_nxt    = r_addr;
        w_rem_nxt     = r_rem;
        w_ref_cnt_nxt = r_ref_cnt;
        w_hold_nxt    = 1'b0;
        w_ref_taken   = 1'b0;
        w_ack         = 1'b0;
        w_wr_next     = 1'b0;
        w_mem_wr      = 1'b0;
        w_mem_rd      = 1'b0;
        w_be          = '0;
        unique case (r_state)
            ST_IDLE: begin
                if (w_ref_pend) begin
                    w_state_nxt   = ST_REFRESH;
                    w_ref_taken   = 1'b1;
                    w_ref_cnt_nxt = RCW'(REF_CYCLES - 1);
                end else if (bus.sdr_req && !r_hold) begin
                    w_ack       = 1'b1;
                    w_addr_nxt  = MEM_AW'(bus.sdr_req_addr);
                    w_rem_nxt   = eff_len(bus.sdr_req_len);
                    w_state_nxt = bus.sdr_req_wr_n ? ST_READ : ST_WRITE;
                end
            end
            ST_REFRESH: begin
                if (r_ref_cnt == '0) begin
                    w_state_nxt = ST_IDLE;
                    w_hold_nxt  = 1'b1;
                end else begin
                    w_ref_cnt_nxt = r_ref_cnt - 1'b1;
                end
            end
            ST_WRITE: begin
                w_wr_next  = 1'b1;
                w_mem_wr   = 1'b1;
                w_be       = ~bus.sdr_wr_en_n;
                w_addr_nxt = r_addr + 1'b1;
                w_rem_nxt  = r_rem - 1'b1;
                if (w_last_beat) begin
                    w_state_nxt = ST_IDLE;
                    w_hold_nxt  = 1'b1;
                end
            end
            ST_READ: begin
                w_mem_rd   = 1'b1;
                w_addr_nxt = r_addr + 1'b1;
                w_rem_nxt  = r_rem - 1'b1;
                if (w_last_beat) begin
                    w_state_nxt = ST_RD_FLUSH;
                end
            end
            ST_RD_FLUSH: begin
                w_state_nxt = ST_IDLE;
                w_hold_nxt  = 1'b1;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Read return lines up with the memory's one-cycle read latency.
    always_ff @(posedge sdram_clk or negedge sdram_resetn) begin
        if (!sdram_resetn) begin
            r_rd_valid <= 1'b0;
            r_rd_last  <= 1'b0;
        end else begin
            r_rd_valid <= w_mem_rd;
            r_rd_last  <= w_mem_rd & w_last_beat;
        end
    end

    assign bus.sdr_req_ack  = w_ack;
    assign bus.sdr_busy_n   = (r_state == ST_IDLE) && !w_ref_pend;
    assign bus.sdr_wr_next  = w_wr_next;
    assign bus.sdr_rd_valid = r_rd_valid;
    assign bus.sdr_last_rd  = r_rd_last;
    assign bus.sdr_rd_data  = r_rd_valid ? bus.mem_rdata : '0;
    assign bus.mem_addr     = r_addr;
    assign bus.mem_wr       = w_mem_wr;
    assign bus.mem_rd       = w_mem_rd;
    assign bus.mem_be       = w_be;
    assign bus.mem_wdata    = w_mem_wr ? bus.sdr_wr_data : '0;
    assign o_dbg_state      = r_state;

endmodule
